// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit user key into 32 round keys, one per clock.
// Ports: CLK/RST_N, KEY_EN+IN_KEY start, DEC_MODE+RK_IDX select, RK_OUT/KEY_READY/BUSY out.
`timescale 1ns/1ps
module sm4_key_expand #(
    parameter int ROUNDS   = 32,
    parameter bit REG_READ = 1'b0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         KEY_EN,
    input  logic [127:0] IN_KEY,
    input  logic         DEC_MODE,
    input  logic [4:0]   RK_IDX,
    output logic [31:0]  RK_OUT,
    output logic         KEY_READY,
    output logic         BUSY
);

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;
    localparam logic [4:0]  LAST = 5'(ROUNDS - 1);

    localparam logic [127:0] SBOX_ROW [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Same S-box as the round datapath; rows hold 16 entries MSB-first.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] r;
        r = SBOX_ROW[x[7:4]] << {x[3:0], 3'b000};
        return r[127:120];
    endfunction

    // Key-schedule T': byte-wise S-box then L'(B) = B ^ B<<<13 ^ B<<<23.
    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // CK[i] byte j = (4i+j)*7 mod 256; 8-bit arithmetic gives the wrap.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [7:0]  b;
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            b = {1'b0, i, 2'(j)};
            b = b * 8'd7;
            w[8*(3-j) +: 8] = b;
        end
        return w;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] k0_q, k1_q, k2_q, k3_q;
    logic [31:0] rk_q [ROUNDS];
    logic        ready_q;
    logic        busy_q;
    logic [31:0] k4_d;
    logic [4:0]  rd_idx;
    logic [31:0] rd_key;

    assign k4_d = k0_q ^ t_prime(k1_q ^ k2_q ^ k3_q ^ ck_word(cnt_q));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (KEY_EN) begin
                        k0_q    <= IN_KEY[127:96] ^ FK0;
                        k1_q    <= IN_KEY[95:64]  ^ FK1;
                        k2_q    <= IN_KEY[63:32]  ^ FK2;
                        k3_q    <= IN_KEY[31:0]   ^ FK3;
                        cnt_q   <= '0;
                        state_q <= S_EXPAND;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    // KEY_EN is deliberately not looked at here.
                    rk_q[cnt_q] <= k4_d;
                    k0_q        <= k1_q;
                    k1_q        <= k2_q;
                    k2_q        <= k3_q;
                    k3_q        <= k4_d;
                    cnt_q       <= cnt_q + 5'd1;
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // 5-bit index keeps 31-RK_IDX in range for every input.
    assign rd_idx = DEC_MODE ? (LAST - RK_IDX) : RK_IDX;
    assign rd_key = rk_q[rd_idx];

    generate
        if (REG_READ) begin : g_reg
            logic [31:0] out_q;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    out_q <= '0;
                end else begin
                    out_q <= ready_q ? rd_key : '0;
                end
            end
            assign RK_OUT = ready_q ? out_q : '0;
        end else begin : g_comb
            assign RK_OUT = ready_q ? rd_key : '0;
        end
    endgenerate

    assign KEY_READY = ready_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand: vector table, scoreboard reads,
// ignored restarts, async reset mid-expansion and continuous restart.
`timescale 1ns/1ps
module tb_sm4_key_expand;

    localparam int           ROUNDS  = 32;
    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [31:0]  RK0     = 32'hF12186F9;
    localparam logic [31:0]  RK1     = 32'h41662B61;
    localparam logic [31:0]  RK31    = 32'h9124A012;

    logic         CLK      = 1'b0;
    logic         RST_N    = 1'b1;
    logic         KEY_EN   = 1'b0;
    logic [127:0] IN_KEY   = '0;
    logic         DEC_MODE = 1'b0;
    logic [4:0]   RK_IDX   = '0;
    logic [31:0]  RK_OUT;
    logic         KEY_READY;
    logic         BUSY;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q [$];

    typedef struct {
        logic        dec;
        logic [4:0]  idx;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [6];

    always #5 CLK = ~CLK;

    sm4_key_expand #(
        .ROUNDS   (ROUNDS),
        .REG_READ (1'b0)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .KEY_EN    (KEY_EN),
        .IN_KEY    (IN_KEY),
        .DEC_MODE  (DEC_MODE),
        .RK_IDX    (RK_IDX),
        .RK_OUT    (RK_OUT),
        .KEY_READY (KEY_READY),
        .BUSY      (BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive a read request, queue its expectation, compare at next negedge.
    task automatic rd_check(input string name, input logic dec,
                            input logic [4:0] idx, input logic [31:0] exp);
        DEC_MODE = dec;
        RK_IDX   = idx;
        sb_q.push_back(exp);
        @(negedge CLK);
        chk(name, RK_OUT, sb_q.pop_front());
    endtask

    task automatic start(input logic [127:0] key);
        @(negedge CLK);
        IN_KEY = key;
        KEY_EN = 1'b1;
        @(posedge CLK);
        #1;
        KEY_EN = 1'b0;
    endtask

    // Counts cycles from acceptance to KEY_READY, bounded at 100.
    task automatic expand_wait(input bit poke, output int lat,
                               output int busy_n, output bit leak);
        lat    = 0;
        busy_n = 0;
        leak   = 1'b0;
        while (lat < 100) begin
            @(negedge CLK);
            if (KEY_READY) break;
            if (BUSY) busy_n++;
            if (RK_OUT !== 32'h0) leak = 1'b1;
            if (poke && (lat == 5 || lat == 20)) begin
                KEY_EN = 1'b1;
                IN_KEY = '0;
            end
            @(posedge CLK);
            #1;
            KEY_EN = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_n;
        bit leak;
        int ready_n;
        int last;

        vecs[0] = '{1'b0, 5'd0,  RK0,  "enc_idx0"};
        vecs[1] = '{1'b0, 5'd1,  RK1,  "enc_idx1"};
        vecs[2] = '{1'b0, 5'd31, RK31, "enc_idx31"};
        vecs[3] = '{1'b1, 5'd0,  RK31, "dec_idx0"};
        vecs[4] = '{1'b1, 5'd30, RK1,  "dec_idx30"};
        vecs[5] = '{1'b1, 5'd31, RK0,  "dec_idx31"};

        #1 RST_N = 1'b0;
        #11;
        chk("rst_ready", 32'(KEY_READY), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_rkout", RK_OUT, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        start(STD_KEY);
        expand_wait(1'b0, lat, busy_n, leak);
        chk("std_latency", 32'(lat), 32'd32);
        chk("std_busy_cycles", 32'(busy_n), 32'd32);
        chk("std_no_leak", 32'(leak), 32'h0);
        chk("std_busy_done", 32'(BUSY), 32'h0);

        for (int i = 0; i < 6; i++) begin
            rd_check(vecs[i].name, vecs[i].dec, vecs[i].idx, vecs[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            rd_check("dec_toggle", i[0], 5'd0, i[0] ? RK31 : RK0);
        end

        start(STD_KEY);
        expand_wait(1'b1, lat, busy_n, leak);
        chk("ign_latency", 32'(lat), 32'd32);
        chk("ign_no_leak", 32'(leak), 32'h0);
        rd_check("ign_rk0", 1'b0, 5'd0, RK0);
        rd_check("ign_rk31", 1'b0, 5'd31, RK31);

        start(STD_KEY);
        repeat (10) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_ready", 32'(KEY_READY), 32'h0);
        chk("midrst_busy", 32'(BUSY), 32'h0);
        chk("midrst_rkout", RK_OUT, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_no_start", 32'({KEY_READY, BUSY}), 32'h0);
        start(STD_KEY);
        expand_wait(1'b0, lat, busy_n, leak);
        chk("post_rst_latency", 32'(lat), 32'd32);
        rd_check("post_rst_rk0", 1'b0, 5'd0, RK0);
        rd_check("post_rst_rk1", 1'b0, 5'd1, RK1);
        rd_check("post_rst_rk31", 1'b0, 5'd31, RK31);

        DEC_MODE = 1'b0;
        RK_IDX   = 5'd31;
        KEY_EN   = 1'b1;
        ready_n  = 0;
        last     = -1;
        leak     = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge CLK);
            if (KEY_READY) begin
                sb_q.push_back(RK31);
                chk("hold_rk31", RK_OUT, sb_q.pop_front());
                if (last >= 0) chk("hold_gap", 32'(c - last), 32'd33);
                last = c;
                ready_n++;
            end else if (RK_OUT !== 32'h0) begin
                leak = 1'b1;
            end
        end
        KEY_EN = 1'b0;
        chk("hold_ready_count", 32'(ready_n), 32'd4);
        chk("hold_no_leak", 32'(leak), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
